decoder_3_8: RTL and testbench

Registered 3-to-8 line decoder with a three-bit enable group, in the style of the 74x138. Enabled, it drives exactly one active-low output line selected by a 3-bit code. Disabled, all lines sit inactive. Used as an address/chip-select decoder; the single output register gives glitch-free selects to downstream logic.

---
 rtl/decoder_3_8_pkg.sv | 12 +
 rtl/decoder_3_8_core.sv | 19 +
 rtl/decoder_3_8.sv | 30 +++
 tb/tb_decoder_3_8.sv | 103 ++++++++++
 4 files changed

// File: rtl/decoder_3_8_pkg.sv
// decoder_3_8_pkg: shared widths, enable code and idle output value
// OUT_IDLE flips to 8'h00 when DECODER_3_8_ACTIVE_HIGH_EN is defined
package decoder_3_8_pkg;
    localparam int SEL_W = 3;
    localparam int OUT_W = 8;
    localparam logic [2:0] EN_ACTIVE = 3'b100;
`ifdef DECODER_3_8_ACTIVE_HIGH_EN
    localparam logic [OUT_W-1:0] OUT_IDLE = 8'h00;
`else
    localparam logic [OUT_W-1:0] OUT_IDLE = 8'hFF;
`endif
endpackage

// File: rtl/decoder_3_8_core.sv
// decoder_3_8_core: combinational enable check and one-hot line decode
// polarity follows DECODER_3_8_ACTIVE_HIGH_EN (active-low lines by default)
module decoder_3_8_core
    import decoder_3_8_pkg::*;
(
    input  logic [2:0]       en,
    input  logic [SEL_W-1:0] data_in,
    output logic [OUT_W-1:0] dec,
    output logic             valid
);
    logic [OUT_W-1:0] one_hot;
    assign valid   = en == EN_ACTIVE;
    assign one_hot = OUT_W'(1) << data_in;
`ifdef DECODER_3_8_ACTIVE_HIGH_EN
    assign dec = valid ? one_hot : OUT_IDLE;
`else
    assign dec = valid ? ~one_hot : OUT_IDLE;
`endif
endmodule

// File: rtl/decoder_3_8.sv
// decoder_3_8: registered 74x138-style 3-to-8 decoder with async active-low reset
// output polarity selectable with DECODER_3_8_ACTIVE_HIGH_EN
module decoder_3_8
    import decoder_3_8_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       en,
    input  logic [SEL_W-1:0] data_in,
    output logic [OUT_W-1:0] data_out,
    output logic             out_valid
);
    logic [OUT_W-1:0] dec;
    logic             valid;
    decoder_3_8_core u_core (
        .en      (en),
        .data_in (data_in),
        .dec     (dec),
        .valid   (valid)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out  <= OUT_IDLE;
            out_valid <= 1'b0;
        end else begin
            data_out  <= dec;
            out_valid <= valid;
        end
    end
endmodule

// File: tb/tb_decoder_3_8.sv
// tb_decoder_3_8: randomized and directed checks against a per-line reference model
module tb_decoder_3_8;
`ifdef DECODER_3_8_ACTIVE_HIGH_EN
    localparam logic ACT = 1'b1;
`else
    localparam logic ACT = 1'b0;
`endif
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [2:0] en = 3'b100;
    logic [2:0] data_in = 3'd5;
    logic [7:0] data_out;
    logic       out_valid;
    int         n_cmp = 0;
    int         n_err = 0;

    decoder_3_8 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .data_in   (data_in),
        .data_out  (data_out),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    function automatic logic ref_on(input logic [2:0] e);
        return e[2] && !e[1] && !e[0];
    endfunction

    // each line is active only when enabled and its index equals the select
    function automatic logic [7:0] ref_dec(input logic [2:0] e, input logic [2:0] d);
        logic [7:0] r;
        for (int i = 0; i < 8; i++)
            r[i] = (ref_on(e) && i == int'(d)) ? ACT : ~ACT;
        return r;
    endfunction

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input string tag, input logic [2:0] e, input logic [2:0] d);
        @(negedge clk);
        en = e;
        data_in = d;
        @(posedge clk);
        #1;
        check({tag, "_dout"}, data_out, ref_dec(e, d));
        check({tag, "_valid"}, {7'b0, out_valid}, {7'b0, ref_on(e)});
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        check("rst_dout", data_out, {8{~ACT}});
        check("rst_valid", {7'b0, out_valid}, 8'h00);
        repeat (3) begin
            @(posedge clk);
            #1;
            check("rst_hold_dout", data_out, {8{~ACT}});
            check("rst_hold_valid", {7'b0, out_valid}, 8'h00);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("release_dout", data_out, ref_dec(3'b100, 3'd5));
        check("release_valid", {7'b0, out_valid}, 8'h01);
        for (int d = 0; d < 8; d++) step("sweep", 3'b100, 3'(d));
        for (int e = 0; e < 8; e++)
            if (e != 4)
                for (int d = 0; d < 8; d++) step("disabled", 3'(e), 3'(d));
        step("drop_on", 3'b100, 3'd2);
        step("drop_off", 3'b101, 3'd0);
        step("hold", 3'b100, 3'd6);
        #2;
        data_in = 3'd1;
        en = 3'b000;
        #1;
        check("hold_between_edges", data_out, ref_dec(3'b100, 3'd6));
        step("async_pre", 3'b100, 3'd7);
        #2 rst_n = 1'b0;
        #1;
        check("async_dout", data_out, {8{~ACT}});
        check("async_valid", {7'b0, out_valid}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 300; k++) begin
            logic [2:0] e, d;
            e = ($urandom_range(0, 1) == 0) ? 3'b100 : 3'($urandom);
            d = 3'($urandom);
            step("rand", e, d);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
